stream_input_rle: RTL and testbench

- Parametrised successor to the MDEC RLE stream front-end.
- Parses the 16-bit (generically RUN_W+COEF_W) compressed coefficient stream into indexed coefficients for the dequantiser, with valid/ready backpressure on both sides.
- Adds registered outputs, out-of-range run detection with forced block close, and a Y-only/colour mode that is sampled only at block boundaries.
- Sits between the MDEC input FIFO and the quant/IDCT write stage.

---
 rtl/stream_input_rle_pkg.sv | 58 +++++
 rtl/stream_input_rle_if.sv | 38 +++
 rtl/stream_input_rle_zigzag_rom.sv | 21 ++
 rtl/stream_input_rle.sv | 191 +++++++++++++++++++
 tb/tb_stream_input_rle.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_input_rle_pkg.sv
// Shared MDEC definitions: block numbering, stream constants, beat metadata.
package stream_input_rle_pkg;

   typedef enum logic [2:0] {
      BLK_Y1 = 3'd0,
      BLK_Y2 = 3'd1,
      BLK_Y3 = 3'd2,
      BLK_Y4 = 3'd3,
      BLK_CR = 3'd4,
      BLK_CB = 3'd5,
      BLK_Y_ = 3'd7
   } mdec_blck_e;

   typedef enum logic {
      LOAD_DC,
      LOAD_OTHER
   } rle_state_e;

   localparam logic [15:0]  EOB_DEFAULT      = 16'hFE00;
   localparam int unsigned  DC_SCALE_DEFAULT = 8;

   // Everything an output beat carries besides the coefficient itself.
   typedef struct packed {
      logic       data_wrt;
      logic [5:0] scale;
      logic       is_dc;
      logic [5:0] index;
      logic [5:0] linear_index;
      logic       full_blk;
      mdec_blck_e block_num;
      logic       block_complete;
      logic       lock_pipe;
   } beat_meta_t;

   // First block of a macroblock for the given mode.
   function automatic mdec_blck_e blk_reload(input logic y_only);
      return y_only ? BLK_Y_ : BLK_CR;
   endfunction

   // Block that follows blk in the macroblock sequence.
   function automatic mdec_blck_e blk_advance(input mdec_blck_e blk, input logic y_only);
      mdec_blck_e nxt;
      if (y_only) begin
         nxt = BLK_Y_;
      end else begin
         case (blk)
            BLK_CR:  nxt = BLK_CB;
            BLK_CB:  nxt = BLK_Y1;
            BLK_Y1:  nxt = BLK_Y2;
            BLK_Y2:  nxt = BLK_Y3;
            BLK_Y3:  nxt = BLK_Y4;
            default: nxt = BLK_CR;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/stream_input_rle_if.sv
// Input word stream plus indexed-coefficient output stream of the RLE front-end.
interface stream_input_rle_if #(
   parameter int unsigned COEF_W = 10,
   parameter int unsigned RUN_W  = 6
);
   logic                    i_valid;
   logic                    o_ready;
   logic [RUN_W+COEF_W-1:0] i_data;
   logic                    i_YOnly;
   logic                    i_clrErr;
   logic                    o_valid;
   logic                    i_ready;
   logic                    o_dataWrt;
   logic [COEF_W-1:0]       o_dataOut;
   logic [5:0]              o_scale;
   logic                    o_isDC;
   logic [5:0]              o_index;
   logic [5:0]              o_linearIndex;
   logic                    o_fullBlockType;
   logic [2:0]              o_blockNum;
   logic                    o_blockComplete;
   logic                    o_lockPipe;
   logic                    o_err;

   modport slave (
      input  i_valid, i_data, i_YOnly, i_clrErr, i_ready,
      output o_ready, o_valid, o_dataWrt, o_dataOut, o_scale, o_isDC, o_index,
             o_linearIndex, o_fullBlockType, o_blockNum, o_blockComplete,
             o_lockPipe, o_err
   );

   modport master (
      output i_valid, i_data, i_YOnly, i_clrErr, i_ready,
      input  o_ready, o_valid, o_dataWrt, o_dataOut, o_scale, o_isDC, o_index,
             o_linearIndex, o_fullBlockType, o_blockNum, o_blockComplete,
             o_lockPipe, o_err
   );
endinterface

// File: rtl/stream_input_rle_zigzag_rom.sv
// Combinational map from zigzag scan position to raster (row*8+col) index.
module mdec_zigzag_rom (
   input  logic [5:0] i_lin,
   output logic [5:0] o_zz
);
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   // Table lookup.
   always_comb begin
      o_zz = ZZ[i_lin];
   end
endmodule

// File: rtl/stream_input_rle.sv
// MDEC RLE stream front-end: parses run/coef words into indexed coefficient
// beats with a single registered output stage and valid/ready on both sides.
module stream_input_rle
   import stream_input_rle_pkg::*;
#(
   parameter int unsigned                 COEF_W   = 10,
   parameter int unsigned                 RUN_W    = 6,
   parameter logic [RUN_W+COEF_W-1:0]     EOB_CODE = (RUN_W+COEF_W)'(EOB_DEFAULT),
   parameter int unsigned                 DC_SCALE = DC_SCALE_DEFAULT
) (
   input  logic              clk,
   input  logic              i_rst,
   stream_input_rle_if.slave bus
);
   localparam int unsigned W          = RUN_W + COEF_W;
   localparam logic [5:0]  SCALE_DC   = 6'(DC_SCALE);
   localparam logic [5:0]  SCALE_FULL = 6'(2 * DC_SCALE);

   rle_state_e        state_q, state_d;
   logic [5:0]        idx_q, idx_d;
   logic [5:0]        scale_q, scale_d;
   logic              full_q, full_d;
   logic              mode_q, mode_d;
   mdec_blck_e        blk_q, blk_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic [COEF_W-1:0] coef_q, coef_d;
   beat_meta_t        meta_q, meta_d;

   logic [RUN_W-1:0]  run;
   logic [COEF_W-1:0] coef_in;
   logic              is_eob;
   logic              load_out;
   logic              accept;
   logic [6:0]        next_idx;
   logic [5:0]        zz_idx;
   logic              emit;
   logic              blk_close;
   logic              err_set;
   mdec_blck_e        dc_blk;

   // Field split and handshake qualifiers for the current input word.
   always_comb begin
      run      = bus.i_data[W-1:COEF_W];
      coef_in  = bus.i_data[COEF_W-1:0];
      is_eob   = (bus.i_data == EOB_CODE);
      load_out = !valid_q || bus.i_ready;
      accept   = bus.i_valid && load_out;
      next_idx = 7'(idx_q) + 7'd1 + 7'(run);
   end

   mdec_zigzag_rom u_zigzag (
      .i_lin (next_idx[5:0]),
      .o_zz  (zz_idx)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (i_rst) state_q <= LOAD_DC;
      else       state_q <= state_d;
   end

   // FSM next state: a block closes on EOB or when the index reaches/passes 63.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            LOAD_DC:    if (!is_eob) state_d = LOAD_OTHER;
            LOAD_OTHER: if (is_eob || next_idx >= 7'd63) state_d = LOAD_DC;
            default:    state_d = LOAD_DC;
         endcase
      end
   end

   // Output beat and per-block context for the accepted word.
   always_comb begin
      idx_d     = idx_q;
      scale_d   = scale_q;
      full_d    = full_q;
      mode_d    = mode_q;
      blk_d     = blk_q;
      valid_d   = valid_q;
      coef_d    = coef_q;
      meta_d    = meta_q;
      dc_blk    = blk_q;
      emit      = 1'b0;
      blk_close = 1'b0;
      err_set   = 1'b0;
      if (accept) begin
         unique case (state_q)
            LOAD_DC: begin
               if (!is_eob) begin
                  // Mode is only honoured here; a change restarts the macroblock.
                  dc_blk = (bus.i_YOnly != mode_q) ? blk_reload(bus.i_YOnly) : blk_q;
                  emit                  = 1'b1;
                  coef_d                = coef_in;
                  meta_d.data_wrt       = 1'b1;
                  meta_d.scale          = (run == '0) ? SCALE_FULL : SCALE_DC;
                  meta_d.is_dc          = 1'b1;
                  meta_d.index          = '0;
                  meta_d.linear_index   = '0;
                  meta_d.full_blk       = (run == '0);
                  meta_d.block_num      = dc_blk;
                  meta_d.block_complete = 1'b0;
                  meta_d.lock_pipe      = 1'b0;
                  idx_d                 = '0;
                  scale_d               = 6'(run);
                  full_d                = (run == '0);
                  mode_d                = bus.i_YOnly;
                  blk_d                 = dc_blk;
               end
            end
            LOAD_OTHER: begin
               emit                  = 1'b1;
               coef_d                = '0;
               meta_d.data_wrt       = 1'b0;
               meta_d.scale          = full_q ? SCALE_FULL : scale_q;
               meta_d.is_dc          = 1'b0;
               meta_d.index          = idx_q;
               meta_d.linear_index   = idx_q;
               meta_d.full_blk       = full_q;
               meta_d.block_num      = blk_q;
               meta_d.block_complete = 1'b0;
               meta_d.lock_pipe      = 1'b0;
               if (is_eob) begin
                  blk_close = 1'b1;
               end else if (next_idx > 7'd63) begin
                  err_set   = 1'b1;
                  blk_close = 1'b1;
               end else begin
                  meta_d.data_wrt     = 1'b1;
                  coef_d              = coef_in;
                  meta_d.linear_index = next_idx[5:0];
                  meta_d.index        = full_q ? next_idx[5:0] : zz_idx;
                  idx_d               = next_idx[5:0];
                  blk_close           = (next_idx == 7'd63);
               end
               if (blk_close) begin
                  meta_d.block_complete = 1'b1;
                  meta_d.lock_pipe      = mode_q || (blk_q == BLK_Y4);
                  blk_d                 = blk_advance(blk_q, mode_q);
                  idx_d                 = '0;
               end
            end
            default: ;
         endcase
      end
      if (load_out) valid_d = emit;
      err_d = (err_q && !bus.i_clrErr) || err_set;
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         idx_q   <= '0;
         scale_q <= '0;
         full_q  <= 1'b0;
         mode_q  <= bus.i_YOnly;
         blk_q   <= blk_reload(bus.i_YOnly);
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         coef_q  <= '0;
         meta_q  <= '0;
      end else begin
         idx_q   <= idx_d;
         scale_q <= scale_d;
         full_q  <= full_d;
         mode_q  <= mode_d;
         blk_q   <= blk_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         coef_q  <= coef_d;
         meta_q  <= meta_d;
      end
   end

   assign bus.o_ready         = load_out;
   assign bus.o_valid         = valid_q;
   assign bus.o_dataWrt       = meta_q.data_wrt;
   assign bus.o_dataOut       = coef_q;
   assign bus.o_scale         = meta_q.scale;
   assign bus.o_isDC          = meta_q.is_dc;
   assign bus.o_index         = meta_q.index;
   assign bus.o_linearIndex   = meta_q.linear_index;
   assign bus.o_fullBlockType = meta_q.full_blk;
   assign bus.o_blockNum      = meta_q.block_num;
   assign bus.o_blockComplete = meta_q.block_complete;
   assign bus.o_lockPipe      = meta_q.lock_pipe;
   assign bus.o_err           = err_q;

endmodule

// File: tb/tb_stream_input_rle.sv
// Self-checking bench for stream_input_rle: directed word sequences, a
// behavioural model that queues expected beats, and a monitor that pops them.
module tb_stream_input_rle;

   typedef struct {
      logic       wrt;
      logic [9:0] coef;
      logic [5:0] scale;
      logic       dc;
      logic [5:0] idx;
      logic [5:0] lin;
      logic [2:0] blk;
      logic       cmp;
      logic       lock;
   } exp_t;

   logic clk = 1'b0;
   logic i_rst;
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   exp_t exp_q[$];

   // Model state
   int         m_dc;
   int         m_idx;
   int         m_scale;
   logic       m_full;
   logic       m_mode;
   int         m_blk;
   logic       m_err;
   int         zz [64];

   stream_input_rle_if #(.COEF_W(10), .RUN_W(6)) bus ();

   stream_input_rle #(
      .COEF_W   (10),
      .RUN_W    (6),
      .EOB_CODE (16'hFE00),
      .DC_SCALE (8)
   ) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       bus.i_ready = 1'($urandom_range(0, 1));
         2:       bus.i_ready = 1'b0;
         default: bus.i_ready = 1'b1;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int next_blk(input int b, input logic y);
      if (y) return 7;
      case (b)
         4: return 5;
         5: return 0;
         0: return 1;
         1: return 2;
         2: return 3;
         default: return 4;
      endcase
   endfunction

   task automatic model_reset();
      m_dc    = 1;
      m_idx   = 0;
      m_scale = 0;
      m_full  = 1'b0;
      m_mode  = bus.i_YOnly;
      m_blk   = bus.i_YOnly ? 7 : 4;
      m_err   = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_word(input logic [15:0] w);
      int   run;
      int   nxt;
      exp_t e;
      logic close;
      run   = int'(w[15:10]);
      close = 1'b0;
      if (m_dc == 1) begin
         if (w != 16'hFE00) begin
            if (bus.i_YOnly != m_mode) m_blk = bus.i_YOnly ? 7 : 4;
            m_mode  = bus.i_YOnly;
            m_scale = run;
            m_full  = (run == 0);
            m_idx   = 0;
            m_dc    = 0;
            e = '{wrt:1'b1, coef:w[9:0], scale:(run == 0) ? 6'd16 : 6'd8, dc:1'b1,
                  idx:6'd0, lin:6'd0, blk:3'(m_blk), cmp:1'b0, lock:1'b0};
            exp_q.push_back(e);
         end
      end else begin
         nxt = m_idx + 1 + run;
         e = '{wrt:1'b0, coef:10'd0, scale:6'd0, dc:1'b0, idx:6'd0, lin:6'd0,
               blk:3'(m_blk), cmp:1'b0, lock:1'b0};
         if (w == 16'hFE00) begin
            close = 1'b1;
         end else if (nxt > 63) begin
            m_err = 1'b1;
            close = 1'b1;
         end else begin
            e.wrt   = 1'b1;
            e.coef  = w[9:0];
            e.scale = m_full ? 6'd16 : 6'(m_scale);
            e.lin   = 6'(nxt);
            e.idx   = m_full ? 6'(nxt) : 6'(zz[nxt]);
            m_idx   = nxt;
            close   = (nxt == 63);
         end
         if (close) begin
            e.cmp  = 1'b1;
            e.lock = m_mode || (m_blk == 3);
            m_blk  = next_blk(m_blk, m_mode);
            m_dc   = 1;
            m_idx  = 0;
         end
         exp_q.push_back(e);
      end
   endtask

   // Drive one word; entered and left just after a rising edge.
   task automatic send(input logic [15:0] w);
      logic done;
      done = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_data  = w;
      for (int n = 0; n < 1000 && !done; n++) begin
         @(negedge clk);
         if (bus.o_ready === 1'b1) begin
            model_word(w);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.o_valid === 1'b0) done = 1'b1;
      end
      chk("drain_timeout", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      model_reset();
   endtask

   // Output monitor: every accepted beat is compared to the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (i_rst === 1'b0 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("dataWrt", 32'(bus.o_dataWrt), 32'(e.wrt));
            chk("isDC", 32'(bus.o_isDC), 32'(e.dc));
            chk("blockNum", 32'(bus.o_blockNum), 32'(e.blk));
            chk("blockComplete", 32'(bus.o_blockComplete), 32'(e.cmp));
            chk("lockPipe", 32'(bus.o_lockPipe), 32'(e.lock));
            if (e.wrt) begin
               chk("dataOut", 32'(bus.o_dataOut), 32'(e.coef));
               chk("scale", 32'(bus.o_scale), 32'(e.scale));
               chk("index", 32'(bus.o_index), 32'(e.idx));
               chk("linearIndex", 32'(bus.o_linearIndex), 32'(e.lin));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int c;
      // zigzag scan order built by walking anti-diagonals
      r = 0;
      c = 0;
      for (int k = 0; k < 64; k++) begin
         zz[k] = r * 8 + c;
         if (((r + c) % 2) == 0) begin
            if (c == 7)      r++;
            else if (r == 0) c++;
            else begin r--; c++; end
         end else begin
            if (r == 7)      c++;
            else if (c == 0) r++;
            else begin r++; c--; end
         end
      end

      bus.i_valid  = 1'b0;
      bus.i_data   = '0;
      bus.i_YOnly  = 1'b0;
      bus.i_clrErr = 1'b0;
      i_rst        = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // reset state
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_err", 32'(bus.o_err), 32'd0);
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_dataOut", 32'(bus.o_dataOut), 32'd0);
      chk("rst_blockNum", 32'(bus.o_blockNum), 32'd0);

      // short RLE block: DC, one AC at zigzag position 2, EOB
      send(16'h2805);
      send(16'h0403);
      send(16'hFE00);
      drain();

      // full block: DC then 63 linear coefficients, trailing EOB swallowed
      send(16'h0001);
      for (int i = 0; i < 63; i++) send(16'(i));
      send(16'hFE00);
      drain();

      // idle EOB words in LOAD_DC produce nothing
      for (int i = 0; i < 3; i++) begin
         chk("eob_ready", 32'(bus.o_ready), 32'd1);
         send(16'hFE00);
      end
      drain();
      chk("eob_no_beats", 32'(bus.o_valid), 32'd0);

      // run overflow forces block close and sets the sticky error
      send(16'h0802);
      send(16'hFC01);
      drain();
      chk("err_set", 32'(bus.o_err), 32'(m_err));
      send(16'h0C07);
      drain();
      chk("err_sticky", 32'(bus.o_err), 32'd1);
      bus.i_clrErr = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clrErr = 1'b0;
      m_err = 1'b0;
      chk("err_clr", 32'(bus.o_err), 32'(m_err));
      send(16'hFE00);
      drain();

      // six colour blocks under random backpressure
      do_reset();
      ready_mode = 1;
      for (int b = 0; b < 6; b++) begin
         send(16'h0C00 | 16'(b));
         send(16'h0405);
         send(16'h03FF);
         send(16'h0807);
         send(16'hFE00);
      end
      ready_mode = 0;
      drain();

      // Y-only request mid-block only affects the next block
      send(16'h0401);
      bus.i_YOnly = 1'b1;
      send(16'h0002);
      send(16'hFE00);
      send(16'h1409);
      send(16'h0C11);
      drain();

      // reset with a held beat and a partial block
      ready_mode = 2;
      send(16'h0C12);
      @(negedge clk);
      chk("held_valid", 32'(bus.o_valid), 32'd1);
      chk("held_dc", 32'(bus.o_isDC), 32'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      chk("rst_mid_valid", 32'(bus.o_valid), 32'd0);
      model_reset();
      ready_mode = 0;
      send(16'h0805);
      send(16'h0006);
      send(16'hFE00);
      drain();
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
